// File: rtl/tm1638_num_fmt.sv
// Binary-to-display formatter for the TM1638 panel driver: a double-dabble
// conversion loop followed by leading-zero blanking and minus-sign placement.
module tm1638_num_fmt #(
  parameter int W      = 16,
  parameter int SIGNED = 1
) (
  input  logic         clkinput,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] value,
  input  logic         blank_lz,
  output logic         busy,
  output logic         done,
  output logic [3:0]   seg7,
  output logic [3:0]   seg6,
  output logic [3:0]   seg5,
  output logic [3:0]   seg4,
  output logic [3:0]   seg3,
  output logic [3:0]   seg2,
  output logic [3:0]   seg1,
  output logic [3:0]   seg0
);

  typedef enum logic [1:0] {IDLE, CONV, FMT} state_t;

  localparam logic [4:0] LAST_ITER = 5'(W - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [4:0]    r_cnt;
  logic [W:0]    r_mag;
  logic [31:0]   r_bcd;
  logic          r_neg;
  logic          r_blank;
  logic          r_done;
  logic [31:0]   r_seg;

  logic          w_neg;
  logic [W:0]    w_ext;
  logic [W:0]    w_mag;
  logic [30:0]   w_adj;
  logic [31:0]   w_seg;
  int            w_top;

  // One extra bit keeps the magnitude of the most negative input exact.
  assign w_neg = (SIGNED != 0) && value[W-1];
  assign w_ext = {w_neg, value};
  assign w_mag = w_neg ? (~w_ext + 1'b1) : w_ext;

  always_ff @(posedge clkinput or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = CONV;
      CONV:    if (r_cnt == LAST_ITER) w_nextState = FMT;
      FMT:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  // The top digit never exceeds 1, so it never needs the add-3 correction.
  always_comb begin
    w_adj = {r_bcd[30:28], 28'd0};
    for (int i = 0; i < 7; i++) begin
      w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                   : r_bcd[4*i +: 4];
    end
  end

  always_comb begin
    w_top = 0;
    for (int i = 1; i < 8; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_top = i;
    end
    w_seg = r_bcd;
    for (int i = 0; i < 8; i++) begin
      if (r_blank && (i > w_top))                 w_seg[4*i +: 4] = 4'hF;
      if (r_neg && r_blank && (i == w_top + 1))   w_seg[4*i +: 4] = 4'hE;
    end
    if (r_neg && !r_blank) w_seg[31:28] = 4'hE;
  end

  always_ff @(posedge clkinput or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mag   <= '0;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
      r_blank <= 1'b0;
      r_done  <= 1'b0;
      r_seg   <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mag   <= w_mag;
            r_neg   <= w_neg;
            r_blank <= blank_lz;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end
        CONV: begin
          r_bcd <= {w_adj, r_mag[W-1]};
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt + 5'd1;
        end
        FMT: begin
          r_seg  <= w_seg;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done = r_done;
  assign {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0} = r_seg;

endmodule

// File: doc/tm1638_num_fmt.md
# tm1638_num_fmt

Sequential binary-to-display formatter that feeds the digit inputs (`seg7`..`seg0`) of the TM1638 panel driver. It accepts a signed or unsigned binary value through a start/busy/done handshake and converts it to eight 4-bit display codes using a W-cycle shift-add-3 (double-dabble) loop. It applies optional leading-zero blanking and places a minus sign. Outputs are registered and held stable between conversions, so the driver can sample them at any point in its refresh frame.

## Interface
- `W`, 16: input value width; legal 4..24.
- `SIGNED`, 1: 1 = `value` is two's complement; 0 = unsigned.
- `clkinput`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  conversion request; sampled on rising edge.
- `value`  in  W  binary value; sampled on the accepting edge only.
- `blank_lz`  in  1  leading-zero blank enable; sampled with `value`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; new codes are valid.
- `seg7`..`seg0`  out  4 each  display codes: 0-9 digit, 4'hE minus, 4'hF blank; `seg0` is the least significant digit.

## Operation
- States: IDLE, CONV, FMT.
- IDLE:
  - `start`=1 latches `value`/`blank_lz`.
  - Computes `neg` = `SIGNED` & `value[W-1]`.
  - Computes magnitude `mag` = `neg` ? -value : value, held in W+1 bits so that -2^(W-1) stays exact.
  - Clears the 32-bit BCD accumulator, sets `busy`, clears the iteration counter, and goes to CONV.
- CONV: each cycle, add 3 to every BCD nibble that is ≥5, then shift {bcd, mag} left by 1. After exactly W iterations (counter W-1 reached), go to FMT.
- FMT (single cycle) writes `seg7`..`seg0`, pulses `done`, clears `busy`, and returns to IDLE.
  - Find `k` = index of the most significant nonzero BCD digit. If the value is zero, `k`=0.
  - `blank_lz`=1: digits above `k` become 4'hF. `seg0` always shows its digit, so zero displays as "0".
  - `neg`=1, `blank_lz`=1: position `k`+1 = 4'hE.
  - `neg`=1, `blank_lz`=0: `seg7` = 4'hE; the other positions show digits including zeros.
  - Width rule: |value| ≤ 2^23 fits in 7 digits for signed W ≤ 24, so the sign position always exists. Unsigned max 2^24-1 fits in 8 digits. No overflow case exists.
- `start` while `busy`=1: ignored, with no queueing. In-flight conversion is unaffected.
- Changes on `value`/`blank_lz` after the accepting edge have no effect.
- `seg*` outputs change only in FMT; they hold their last values otherwise.

## Timing
- Reset (`rst_n`=0, async): state IDLE, `busy`=0, `done`=0, all `seg*`=4'hF, accumulator cleared. Reset mid-conversion aborts; no `done` is produced.
- `start` accepted at edge N gives:
  - `busy`=1 after edge N.
  - CONV on edges N+1..N+W.
  - FMT at edge N+W+1: `seg*` updated and `done`=1 for exactly one cycle, `busy`=0.
- Latency: W+1 cycles from accepting edge to valid outputs (17 for W=16).
- The earliest next accepting edge is N+W+2. Sustained throughput is one conversion per W+2 cycles.
- `start` held high continuously: re-accepted at every IDLE edge, i.e. back-to-back conversions.

## Test plan
- Reset, then `start` with `value`=0, `blank_lz`=1 -> `done` at 17 cycles after acceptance; `seg0`=0, `seg7`..`seg1`=F; prior to `done`, `seg*` all F.
- `value`=1234, `blank_lz`=1 -> `seg3..0`=1,2,3,4, `seg7..4`=F. Same value with `blank_lz`=0 -> `seg7..0`=0,0,0,0,1,2,3,4.
- `value`=16'h8000 (-32768), `blank_lz`=1 -> `seg5`=E, `seg4..0`=3,2,7,6,8, `seg7..6`=F. `value`=16'hFFFF -> `seg1`=E, `seg0`=1, rest F. With `blank_lz`=0 -> `seg7`=E, `seg6..1`=0, `seg0`=1.
- `SIGNED`=0, W=24, `value`=24'hFFFFFF -> `seg7..0`=1,6,7,7,7,2,1,5; no sign.
- `start` pulses at cycles 3 and 8 after an accepted `start` -> both ignored, exactly one `done`, outputs reflect the first value. `start` held high -> `done` every 18 cycles.
- `rst_n` asserted at CONV iteration 5 -> `busy`=0 and `seg*`=F immediately (asynchronous), with no `done`. The next `start` after release converts correctly.
